synt_seq: RTL and testbench

Power-up and calibration sequencer for the frequency synthesizer stage. It sits directly upstream of the synthesizer and drives its PU_SYNT and CAL_SYNT inputs. It waits for RDY_SYNT with a bounded timeout, retries a failed lock by power-cycling the synthesizer, and reports a qualified lock (SYNT_OK) or a sticky failure (ERR) to the radio controller.

---
 rtl/synt_seq_if.sv | 56 +++++
 rtl/synt_seq.sv | 213 +++++++++++++++++++++
 tb/tb_synt_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/synt_seq_if.sv
// ----------------------------------------------------------------------------
// synt_seq_if
//
// Groups the sequencer's control/status signals so they can be passed as a
// single port between the radio controller side and the synthesizer sequencer.
//
// Signals:
//   en         controller -> sequencer  synthesizer requested on (level)
//   rdy_synt   synth      -> sequencer  ready/lock indication from the synthesizer
//   pu_synt    sequencer  -> synth      synthesizer power-up
//   cal_synt   sequencer  -> synth      synthesizer calibration request
//   synt_ok    sequencer  -> controller qualified lock
//   err        sequencer  -> controller lock failed after all retries (sticky)
//   lock_lost  sequencer  -> controller one-cycle pulse on loss of lock
//   retry_cnt  sequencer  -> controller retries used in current attempt budget
//
// Modports:
//   slave   the sequencer itself
//   master  the environment driving it (controller + synthesizer model)
// ----------------------------------------------------------------------------
interface synt_seq_if #(
    parameter int unsigned RTY_W = 4
) ();

    logic             en;
    logic             rdy_synt;
    logic             pu_synt;
    logic             cal_synt;
    logic             synt_ok;
    logic             err;
    logic             lock_lost;
    logic [RTY_W-1:0] retry_cnt;

    modport slave (
        input  en,
        input  rdy_synt,
        output pu_synt,
        output cal_synt,
        output synt_ok,
        output err,
        output lock_lost,
        output retry_cnt
    );

    modport master (
        output en,
        output rdy_synt,
        input  pu_synt,
        input  cal_synt,
        input  synt_ok,
        input  err,
        input  lock_lost,
        input  retry_cnt
    );

endinterface

// File: rtl/synt_seq.sv
// ----------------------------------------------------------------------------
// synt_seq
//
// Power-up and calibration sequencer for the frequency synthesizer. Powers the
// synthesizer up, lets it settle, issues a calibration pulse, then waits a
// bounded time for RDY. A missed lock power-cycles the synthesizer and retries
// up to MAX_RETRY times before raising a sticky error. Loss of RDY while locked
// pulses lock_lost and re-sequences without consuming a retry.
//
// Ports:
//   clk_i    clock, all logic on the rising edge
//   rst_ni   synchronous active-low reset
//   sq_io    synt_seq_if.slave bundle:
//              en, rdy_synt                         (inputs)
//              pu_synt, cal_synt, synt_ok, err,
//              lock_lost, retry_cnt                 (registered outputs)
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register.
// ----------------------------------------------------------------------------
module synt_seq #(
    parameter int unsigned PU_SETTLE    = 8,
    parameter int unsigned CAL_PULSE    = 2,
    parameter int unsigned LOCK_TIMEOUT = 2000,
    parameter int unsigned RETRY_GAP    = 4,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RTY_W        = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    synt_seq_if.slave  sq_io
);

    typedef enum logic [2:0] {
        StIdle,
        StPwrup,
        StCal,
        StWaitRdy,
        StLocked,
        StBackoff,
        StFail
    } state_e;

    // Terminal counts: a phase ends on the edge where the counter already holds
    // its last value, giving exactly N cycles per phase.
    localparam logic [CNT_W-1:0] PuLast  = CNT_W'(PU_SETTLE - 1);
    localparam logic [CNT_W-1:0] CalLast = CNT_W'(CAL_PULSE - 1);
    localparam logic [CNT_W-1:0] ToLast  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GapLast = CNT_W'(RETRY_GAP - 1);
    localparam logic [RTY_W-1:0] RtyMax  = RTY_W'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    logic pu_q, pu_d;
    logic cal_q, cal_d;
    logic ok_q, ok_d;
    logic err_q, err_d;
    logic lost_q, lost_d;

    // ------------------------------------------------------------------------
    // Next-state, counter and retry logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;

        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                retry_d = '0;
                if (sq_io.en) begin
                    state_d = StPwrup;
                end
            end

            // RDY is deliberately ignored while the synthesizer settles.
            StPwrup: begin
                if (cnt_q == PuLast) begin
                    state_d = StCal;
                    cnt_d   = '0;
                end
            end

            // The counter starting here is the lock timer; it keeps running
            // into StWaitRdy so the timeout is measured from the CAL rise.
            StCal: begin
                if (sq_io.rdy_synt) begin
                    state_d = StLocked;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == CalLast) begin
                    state_d = StWaitRdy;
                end
            end

            // RDY on the timeout cycle still wins.
            StWaitRdy: begin
                if (sq_io.rdy_synt) begin
                    state_d = StLocked;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == ToLast) begin
                    cnt_d = '0;
                    if (retry_q < RtyMax) begin
                        state_d = StBackoff;
                        retry_d = retry_q + 1'b1;
                    end else begin
                        state_d = StFail;
                    end
                end
            end

            // Lock loss re-sequences without consuming a retry.
            StLocked: begin
                cnt_d = '0;
                if (!sq_io.rdy_synt) begin
                    state_d = StBackoff;
                end
            end

            StBackoff: begin
                if (cnt_q == GapLast) begin
                    state_d = StPwrup;
                    cnt_d   = '0;
                end
            end

            StFail: begin
                cnt_d = '0;
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase

        // Dropping the request overrides every other transition.
        if (state_q != StIdle && !sq_io.en) begin
            state_d = StIdle;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state
    // ------------------------------------------------------------------------
    always_comb begin
        pu_d   = 1'b0;
        cal_d  = 1'b0;
        ok_d   = 1'b0;
        err_d  = 1'b0;
        lost_d = 1'b0;

        unique case (state_d)
            StPwrup:   pu_d = 1'b1;
            StCal: begin
                pu_d  = 1'b1;
                cal_d = 1'b1;
            end
            StWaitRdy: pu_d = 1'b1;
            StLocked: begin
                pu_d = 1'b1;
                ok_d = 1'b1;
            end
            StFail:    err_d = 1'b1;
            default: begin
                pu_d = 1'b0;
            end
        endcase

        lost_d = (state_q == StLocked) && (state_d == StBackoff);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
            pu_q    <= 1'b0;
            cal_q   <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            pu_q    <= pu_d;
            cal_q   <= cal_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    assign sq_io.pu_synt   = pu_q;
    assign sq_io.cal_synt  = cal_q;
    assign sq_io.synt_ok   = ok_q;
    assign sq_io.err       = err_q;
    assign sq_io.lock_lost = lost_q;
    assign sq_io.retry_cnt = retry_q;

endmodule

// File: tb/tb_synt_seq.sv
// ----------------------------------------------------------------------------
// tb_synt_seq
//
// Drives the sequencer through directed scenarios and a randomized run, and
// compares every output after every edge with a reference model that tracks
// the sequence as "mode + elapsed cycles since the current attempt began".
// ----------------------------------------------------------------------------
module tb_synt_seq;

    localparam int unsigned PS = 4;
    localparam int unsigned CP = 2;
    localparam int unsigned LT = 20;
    localparam int unsigned RG = 3;
    localparam int unsigned MR = 2;

    localparam int MOff  = 0;
    localparam int MSeq  = 1;
    localparam int MLock = 2;
    localparam int MBack = 3;
    localparam int MFail = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    synt_seq_if #(.RTY_W(4)) sq ();

    synt_seq #(
        .PU_SETTLE    (PS),
        .CAL_PULSE    (CP),
        .LOCK_TIMEOUT (LT),
        .RETRY_GAP    (RG),
        .MAX_RETRY    (MR),
        .CNT_W        (16),
        .RTY_W        (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sq_io  (sq)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: t counts cycles since PU_SYNT rose for the current
    // attempt (SEQ) or since PU_SYNT fell (BACK).
    int m_mode  = MOff;
    int m_t     = 0;
    int m_retry = 0;
    bit m_lost  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit d);
        m_lost = 1'b0;
        if (!r) begin
            m_mode  = MOff;
            m_t     = 0;
            m_retry = 0;
        end else if (m_mode != MOff && !e) begin
            m_mode  = MOff;
            m_t     = 0;
            m_retry = 0;
        end else begin
            case (m_mode)
                MOff: begin
                    if (e) begin
                        m_mode = MSeq;
                        m_t    = 0;
                    end
                end
                MSeq: begin
                    if (m_t >= int'(PS) && d) begin
                        m_mode  = MLock;
                        m_retry = 0;
                    end else if (m_t == int'(PS + LT) - 1) begin
                        if (m_retry < int'(MR)) begin
                            m_retry++;
                            m_mode = MBack;
                            m_t    = 0;
                        end else begin
                            m_mode = MFail;
                        end
                    end else begin
                        m_t++;
                    end
                end
                MLock: begin
                    if (!d) begin
                        m_mode = MBack;
                        m_t    = 0;
                        m_lost = 1'b1;
                    end
                end
                MBack: begin
                    if (m_t == int'(RG) - 1) begin
                        m_mode = MSeq;
                        m_t    = 0;
                    end else begin
                        m_t++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        bit e_pu;
        bit e_cal;
        e_pu  = (m_mode == MSeq) || (m_mode == MLock);
        e_cal = (m_mode == MSeq) && (m_t >= int'(PS)) && (m_t < int'(PS + CP));
        chk("pu_synt",   32'(sq.pu_synt),   32'(e_pu));
        chk("cal_synt",  32'(sq.cal_synt),  32'(e_cal));
        chk("synt_ok",   32'(sq.synt_ok),   32'(m_mode == MLock));
        chk("err",       32'(sq.err),       32'(m_mode == MFail));
        chk("lock_lost", 32'(sq.lock_lost), 32'(m_lost));
        chk("retry_cnt", 32'(sq.retry_cnt), 32'(m_retry));
    endtask

    // One clock edge: apply inputs, let the edge pass, advance the model,
    // then sample outputs away from the edge.
    task automatic tick(input bit r, input bit e, input bit d);
        rst_n       = r;
        sq.en       = e;
        sq.rdy_synt = d;
        @(posedge clk);
        model_step(r, e, d);
        #1;
        check_all();
    endtask

    task automatic go_idle();
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int  e;
        int  cal_rises;
        bit  prev_cal;
        bit  r_en;
        bit  r_rdy;
        bit  r_rst;

        rst_n       = 1'b0;
        sq.en       = 1'b0;
        sq.rdy_synt = 1'b0;

        // Reset state, EN held high during reset must not start a sequence.
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        chk("reset_pu", 32'(sq.pu_synt), 32'd0);
        tick(1'b1, 1'b0, 1'b0);

        // Normal lock: EN at edge 0, RDY from edge 10.
        for (int i = 0; i <= 12; i++) begin
            tick(1'b1, 1'b1, i >= 10);
            if (i == 0) chk("norm_pu_e0", 32'(sq.pu_synt), 32'd1);
            if (i == 4) chk("norm_cal_e4", 32'(sq.cal_synt), 32'd1);
            if (i == 6) chk("norm_cal_e6", 32'(sq.cal_synt), 32'd0);
            if (i == 9) chk("norm_ok_e9", 32'(sq.synt_ok), 32'd0);
            if (i == 10) chk("norm_ok_e10", 32'(sq.synt_ok), 32'd1);
        end
        go_idle();

        // Single retry: no RDY in attempt 1 (timeout at edge 24), RDY at 40.
        for (int i = 0; i <= 42; i++) begin
            tick(1'b1, 1'b1, i >= 40);
            if (i == 23) chk("rty_pu_e23", 32'(sq.pu_synt), 32'd1);
            if (i == 24) chk("rty_pu_e24", 32'(sq.pu_synt), 32'd0);
            if (i == 26) chk("rty_pu_e26", 32'(sq.pu_synt), 32'd0);
            if (i == 27) chk("rty_pu_e27", 32'(sq.pu_synt), 32'd1);
            if (i == 39) chk("rty_cnt_e39", 32'(sq.retry_cnt), 32'd1);
            if (i == 40) chk("rty_cnt_e40", 32'(sq.retry_cnt), 32'd0);
        end

        // Lock loss: one low RDY sample while locked.
        tick(1'b1, 1'b1, 1'b0);
        chk("loss_pulse", 32'(sq.lock_lost), 32'd1);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b1);
        chk("loss_relock", 32'(sq.synt_ok), 32'd1);
        go_idle();

        // Exhausted retries: expect 3 CAL pulses and ERR 78 edges after EN.
        tick(1'b1, 1'b1, 1'b0);
        e         = 0;
        cal_rises = 0;
        prev_cal  = 1'b0;
        while (sq.err !== 1'b1 && e < 200) begin
            tick(1'b1, 1'b1, 1'b0);
            e++;
            if (sq.cal_synt === 1'b1 && !prev_cal) cal_rises++;
            prev_cal = (sq.cal_synt === 1'b1);
        end
        chk("exh_edges_to_err", 32'(e), 32'd78);
        chk("exh_cal_pulses", 32'(cal_rises), 32'd3);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1);
        chk("exh_err_sticky", 32'(sq.err), 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        chk("exh_err_clear", 32'(sq.err), 32'd0);
        chk("exh_rty_clear", 32'(sq.retry_cnt), 32'd0);

        // Abort during CAL, then reset during WAIT_RDY and restart.
        for (int i = 0; i <= 4; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("abort_pu", 32'(sq.pu_synt), 32'd0);
        for (int i = 0; i <= 10; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("rst_mid_pu", 32'(sq.pu_synt), 32'd0);
        tick(1'b1, 1'b1, 1'b0);
        chk("rst_release_pu", 32'(sq.pu_synt), 32'd1);
        go_idle();

        // Race: RDY first seen on the timeout edge (24).
        for (int i = 0; i <= 26; i++) tick(1'b1, 1'b1, i == 24 || i > 24);
        chk("race_ok", 32'(sq.synt_ok), 32'd1);
        chk("race_rty", 32'(sq.retry_cnt), 32'd0);
        go_idle();

        // Randomized run against the model.
        r_en  = 1'b1;
        r_rdy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) r_en = ~r_en;
            if ($urandom_range(0, 11) == 0) r_rdy = ~r_rdy;
            r_rst = ($urandom_range(0, 299) != 0);
            tick(r_rst, r_en, r_rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
